// File: rtl/fadd_cal_stage_if.sv
// Bus between the align/cal pipeline register and the cal/nor pipeline register
// of the pipelined FP adder.
//  c_* : operation entering the calculation stage (driven by the upstream stage)
//  n_* : registered result presented to the normalisation stage
//  master : upstream/consumer side (drives c_*, observes n_*)
//  slave  : calculation stage itself (observes c_*, drives n_*)
interface fadd_cal_stage_if;
    localparam int unsigned FRAC_W  = 27;
    localparam int unsigned LFRAC_W = 24;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned CAL_W   = FRAC_W + 1;

    logic                c_valid;
    logic [FRAC_W-1:0]   c_small_frac;
    logic [LFRAC_W-1:0]  c_large_frac;
    logic [MANT_W-1:0]   c_inf_nan_frac;
    logic [EXP_W-1:0]    c_exp;
    logic [1:0]          c_rm;
    logic                c_is_nan;
    logic                c_is_inf;
    logic                c_sign;
    logic                c_op_sub;

    logic                n_valid;
    logic [CAL_W-1:0]    n_cal_frac;
    logic [MANT_W-1:0]   n_inf_nan_frac;
    logic [EXP_W-1:0]    n_exp;
    logic [1:0]          n_rm;
    logic                n_is_nan;
    logic                n_is_inf;
    logic                n_sign;
    logic                n_zero;

    modport master (
        output c_valid, c_small_frac, c_large_frac, c_inf_nan_frac, c_exp, c_rm,
               c_is_nan, c_is_inf, c_sign, c_op_sub,
        input  n_valid, n_cal_frac, n_inf_nan_frac, n_exp, n_rm,
               n_is_nan, n_is_inf, n_sign, n_zero
    );

    modport slave (
        input  c_valid, c_small_frac, c_large_frac, c_inf_nan_frac, c_exp, c_rm,
               c_is_nan, c_is_inf, c_sign, c_op_sub,
        output n_valid, n_cal_frac, n_inf_nan_frac, n_exp, n_rm,
               n_is_nan, n_is_inf, n_sign, n_zero
    );
endinterface

// File: rtl/fadd_cal_stage.sv
// Calculation stage of the pipelined FP adder: adds or subtracts the aligned
// fractions, resolves the sign of an exact-zero difference and registers the
// result into the cal/nor pipeline register (1-cycle latency).
//  clk   : rising-edge clock
//  clrn  : asynchronous active-low reset, clears every n_* output
//  e     : stage enable, 0 = stall (all registers hold, flush ignored)
//  flush : cancel the operation entering this cycle (clears n_valid only)
//  bus   : c_* operation in, n_* registered result out
module fadd_cal_stage (
    input  logic             clk,
    input  logic             clrn,
    input  logic             e,
    input  logic             flush,
    fadd_cal_stage_if.slave  bus
);
    localparam int unsigned FRAC_W = 27;
    localparam int unsigned CAL_W  = FRAC_W + 1;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned EXP_W  = 8;

    logic [CAL_W-1:0]  large_c;
    logic [CAL_W-1:0]  small_c;
    logic [CAL_W-1:0]  cal_c;
    logic              zero_c;
    logic              sign_c;

    logic              valid_q;
    logic [CAL_W-1:0]  cal_q;
    logic [MANT_W-1:0] inf_nan_frac_q;
    logic [EXP_W-1:0]  exp_q;
    logic [1:0]        rm_q;
    logic              is_nan_q;
    logic              is_inf_q;
    logic              sign_q;
    logic              zero_q;

    // Align the larger fraction with the GRS bits of the smaller one; upstream
    // guarantees large >= small, so the difference never wraps.
    assign large_c = {1'b0, bus.c_large_frac, 3'b000};
    assign small_c = {1'b0, bus.c_small_frac};
    assign cal_c   = bus.c_op_sub ? (large_c - small_c) : (large_c + small_c);

    // An exact cancellation is +0 except when rounding toward -inf.
    assign zero_c  = (cal_c == '0) & ~bus.c_is_nan & ~bus.c_is_inf;
    assign sign_c  = (zero_c & bus.c_op_sub) ? (bus.c_rm == 2'b11) : bus.c_sign;

    // cal/nor pipeline register; data loads even on flush or idle slots.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q        <= 1'b0;
            cal_q          <= '0;
            inf_nan_frac_q <= '0;
            exp_q          <= '0;
            rm_q           <= '0;
            is_nan_q       <= 1'b0;
            is_inf_q       <= 1'b0;
            sign_q         <= 1'b0;
            zero_q         <= 1'b0;
        end else if (e) begin
            valid_q        <= bus.c_valid & ~flush;
            cal_q          <= cal_c;
            inf_nan_frac_q <= bus.c_inf_nan_frac;
            exp_q          <= bus.c_exp;
            rm_q           <= bus.c_rm;
            is_nan_q       <= bus.c_is_nan;
            is_inf_q       <= bus.c_is_inf;
            sign_q         <= sign_c;
            zero_q         <= zero_c;
        end
    end

    assign bus.n_valid        = valid_q;
    assign bus.n_cal_frac     = cal_q;
    assign bus.n_inf_nan_frac = inf_nan_frac_q;
    assign bus.n_exp          = exp_q;
    assign bus.n_rm           = rm_q;
    assign bus.n_is_nan       = is_nan_q;
    assign bus.n_is_inf       = is_inf_q;
    assign bus.n_sign         = sign_q;
    assign bus.n_zero         = zero_q;
endmodule

// File: tb/tb_fadd_cal_stage.sv
// Self-checking bench for fadd_cal_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the FP add/sub stage.
module tb_fadd_cal_stage;
    logic clk;
    logic clrn;
    logic e;
    logic flush;

    fadd_cal_stage_if bus ();

    fadd_cal_stage dut (
        .clk   (clk),
        .clrn  (clrn),
        .e     (e),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected n_* as {valid, cal[27:0], inf_nan_frac, exp, rm, nan, inf, sign, zero}
    logic [65:0] m_q;
    // Last load was flushed: only the valid bit is meaningful.
    logic        m_dc;

    // Value the stage should compute from the current c_* inputs.
    function automatic logic [64:0] model_calc();
        longint l, s, r;
        logic   z, sg;
        l  = longint'(bus.c_large_frac) * 8;
        s  = longint'(bus.c_small_frac);
        r  = bus.c_op_sub ? (l - s) : (l + s);
        z  = (r == 0) && !bus.c_is_nan && !bus.c_is_inf;
        sg = (z && bus.c_op_sub) ? (bus.c_rm == 2'd3) : bus.c_sign;
        return {28'(r), bus.c_inf_nan_frac, bus.c_exp, bus.c_rm,
                bus.c_is_nan, bus.c_is_inf, sg, z};
    endfunction

    function automatic logic [65:0] observed();
        return {bus.n_valid, bus.n_cal_frac, bus.n_inf_nan_frac, bus.n_exp, bus.n_rm,
                bus.n_is_nan, bus.n_is_inf, bus.n_sign, bus.n_zero};
    endfunction

    // Advance one clock, updating the model from what is sampled at the edge.
    task automatic step();
        logic [64:0] d;
        d = model_calc();
        if (!clrn) begin
            m_q  = '0;
            m_dc = 1'b0;
        end else if (e) begin
            m_q  = {bus.c_valid & ~flush, d};
            m_dc = flush;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [23:0] l, input logic [26:0] s, input logic sub,
                          input logic sg, input logic [1:0] rm);
        bus.c_valid        = 1'b1;
        bus.c_large_frac   = l;
        bus.c_small_frac   = s;
        bus.c_op_sub       = sub;
        bus.c_sign         = sg;
        bus.c_rm           = rm;
        bus.c_is_nan       = 1'b0;
        bus.c_is_inf       = 1'b0;
        bus.c_exp          = 8'd127;
        bus.c_inf_nan_frac = 23'h0;
    endtask

    // Random legal operation: hidden bit set, small aligned fraction never above large.
    task automatic rand_op();
        longint l8;
        bus.c_valid        = 1'($urandom);
        bus.c_large_frac   = 24'h800000 | 24'($urandom);
        bus.c_op_sub       = 1'($urandom);
        l8                 = longint'(bus.c_large_frac) * 8;
        if ($urandom_range(0, 5) == 0)
            bus.c_small_frac = 27'(l8);
        else
            bus.c_small_frac = 27'(longint'($urandom) % (l8 + 1));
        bus.c_inf_nan_frac = 23'($urandom);
        bus.c_exp          = 8'($urandom);
        bus.c_rm           = 2'($urandom);
        bus.c_sign         = 1'($urandom);
        bus.c_is_nan       = ($urandom_range(0, 9) == 0);
        bus.c_is_inf       = ($urandom_range(0, 9) == 0);
    endtask

    task automatic test_reset();
        logic [65:0] g;
        g = observed();
        total++;
        if (g !== 66'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", g);
        end
        @(negedge clk);
        clrn = 1'b1;
        m_q  = '0;
        m_dc = 1'b0;
    endtask

    task automatic test_add();
        set_op(24'h800000, 27'h4000000, 1'b0, 1'b0, 2'd0);
        e = 1'b1; flush = 1'b0;
        step();
        total++;
        if (bus.n_cal_frac !== 28'h8000000 || bus.n_valid !== 1'b1 || bus.n_zero !== 1'b0) begin
            bad++;
            $display("FAIL add_1p1 got cal=%h v=%b z=%b want cal=8000000 v=1 z=0",
                     bus.n_cal_frac, bus.n_valid, bus.n_zero);
        end
        total++;
        if (observed() !== m_q) begin
            bad++;
            $display("FAIL add_model got=%h want=%h", observed(), m_q);
        end
    endtask

    task automatic test_cancel();
        for (int k = 0; k < 2; k++) begin
            set_op(24'hC00000, 27'h6000000, 1'b1, 1'b0, (k == 0) ? 2'd0 : 2'd3);
            step();
            total++;
            if (bus.n_cal_frac !== 28'h0 || bus.n_zero !== 1'b1 || bus.n_sign !== 1'(k)) begin
                bad++;
                $display("FAIL cancel_rm%0d got cal=%h z=%b s=%b want cal=0 z=1 s=%0d",
                         k * 3, bus.n_cal_frac, bus.n_zero, bus.n_sign, k);
            end
        end
    endtask

    task automatic test_stall();
        logic [65:0] snap;
        set_op(24'hA5A5A5, 27'h0123456, 1'b1, 1'b1, 2'd2);
        e = 1'b1;
        step();
        snap = m_q;
        e = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_op();
            flush = 1'($urandom);
            step();
            total++;
            if (observed() !== snap) begin
                bad++;
                $display("FAIL stall_hold%0d got=%h want=%h", k, observed(), snap);
            end
        end
        flush = 1'b0;
        e = 1'b1;
        set_op(24'hFFFFFF, 27'h7FFFFFF, 1'b0, 1'b0, 2'd1);
        step();
        total++;
        if (observed() !== m_q || bus.n_cal_frac !== 28'hFFFFFF7) begin
            bad++;
            $display("FAIL stall_resume got=%h want=%h", observed(), m_q);
        end
    endtask

    task automatic test_flush();
        set_op(24'h900000, 27'h0000010, 1'b0, 1'b0, 2'd0);
        e = 1'b1; flush = 1'b1;
        step();
        total++;
        if (bus.n_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_kill got v=%b want v=0", bus.n_valid);
        end
        flush = 1'b0;
        step();
        flush = 1'b1; e = 1'b0;
        step();
        total++;
        if (bus.n_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_stalled got v=%b want v=1", bus.n_valid);
        end
        flush = 1'b0; e = 1'b1;
    endtask

    task automatic test_nan();
        set_op(24'hB00000, 27'h5800000, 1'b1, 1'b1, 2'd3);
        bus.c_is_nan       = 1'b1;
        bus.c_inf_nan_frac = 23'h400001;
        step();
        total++;
        if (bus.n_zero !== 1'b0 || bus.n_is_nan !== 1'b1 || bus.n_sign !== 1'b1 ||
            bus.n_inf_nan_frac !== 23'h400001) begin
            bad++;
            $display("FAIL nan_pass got z=%b nan=%b s=%b f=%h want z=0 nan=1 s=1 f=400001",
                     bus.n_zero, bus.n_is_nan, bus.n_sign, bus.n_inf_nan_frac);
        end
    endtask

    task automatic test_random();
        logic [65:0] g;
        for (int k = 0; k < 300; k++) begin
            rand_op();
            e     = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            step();
            g = observed();
            total++;
            if (m_dc ? (g[65] !== m_q[65]) : (g !== m_q)) begin
                bad++;
                $display("FAIL random%0d got=%h want=%h", k, g, m_q);
            end
        end
        e = 1'b1; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        set_op(24'hC12345, 27'h0ABCDEF, 1'b0, 1'b1, 2'd0);
        step();
        total++;
        if (bus.n_valid !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre got v=%b want v=1", bus.n_valid);
        end
        #2;
        clrn = 1'b0;
        #1;
        total++;
        if (observed() !== 66'h0) begin
            bad++;
            $display("FAIL arst_immediate got=%h want=0", observed());
        end
        step();
        total++;
        if (observed() !== 66'h0) begin
            bad++;
            $display("FAIL arst_held got=%h want=0", observed());
        end
        #2;
        clrn = 1'b1;
        set_op(24'h876543, 27'h0000007, 1'b1, 1'b0, 2'd2);
        step();
        total++;
        if (observed() !== m_q || bus.n_valid !== 1'b1) begin
            bad++;
            $display("FAIL arst_reload got=%h want=%h", observed(), m_q);
        end
    endtask

    initial begin
        clrn  = 1'b0;
        e     = 1'b1;
        flush = 1'b0;
        m_q   = '0;
        m_dc  = 1'b0;
        set_op(24'h800000, 27'h0, 1'b0, 1'b0, 2'd0);
        #12;
        test_reset();
        test_add();
        test_cancel();
        test_stall();
        test_flush();
        test_nan();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
